// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C bus-monitor state encoding and default timing constants
package i2c_pkg;

    // Consecutive equal synchronized samples needed to move a filtered line.
    localparam int FILTER_LEN_DEF  = 4;
    // Bus-free hold time in clk cycles (5 us at 100 MHz).
    localparam int TBUF_CYCLES_DEF = 500;
    // Width of the bus-idle counter; must hold TBUF_CYCLES-1.
    localparam int IDLE_CNT_W      = 10;

    typedef enum logic [1:0] {
        WAIT_FREE = 2'd0,
        FREE      = 2'd1,
        BUSY      = 2'd2
    } bus_state_t;

endpackage

// File: rtl/protocol_detect_if.sv
// rtl/protocol_detect_if.sv - pad inputs and condition/status outputs of the I2C protocol detector
//
// scl_in, sda_in   : raw pad values, asynchronous to clk (driven by master side)
// start_det        : one-cycle pulse on every START, including repeated START
// rstart_det       : one-cycle pulse on a START seen while the bus is busy
// stop_det         : one-cycle pulse on STOP
// scl_rise/fall    : one-cycle pulse on each filtered SCL edge
// bus_busy         : high from START until STOP
// bus_free         : high once both lines have been idle-high for the hold time
interface protocol_detect_if;

    logic scl_in;
    logic sda_in;
    logic start_det;
    logic rstart_det;
    logic stop_det;
    logic scl_rise;
    logic scl_fall;
    logic bus_busy;
    logic bus_free;

    modport master (
        output scl_in, sda_in,
        input  start_det, rstart_det, stop_det, scl_rise, scl_fall, bus_busy, bus_free
    );

    modport slave (
        input  scl_in, sda_in,
        output start_det, rstart_det, stop_det, scl_rise, scl_fall, bus_busy, bus_free
    );

endinterface

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - 2-flop synchronizer plus majority-free glitch filter for one I2C line
//
// clk      : reference clock
// reset    : synchronous active-high reset; presets the line to released (1)
// line_in  : raw pad value, asynchronous to clk
// filtered : registered line value, moves only after FILTER_LEN equal samples
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic filtered
);

    logic [1:0]            sync;
    logic [FILTER_LEN-1:0] samples;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync     <= '1;
            samples  <= '1;
            filtered <= 1'b1;
        end else begin
            sync    <= {sync[0], line_in};
            samples <= {samples[FILTER_LEN-2:0], sync[1]};
            // Mixed windows hold the previous value, which rejects short glitches.
            if (&samples) begin
                filtered <= 1'b1;
            end else if (~|samples) begin
                filtered <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/protocol_detect.sv
// rtl/protocol_detect.sv - I2C START/STOP/edge detector with bus busy/free tracking
//
// clk   : 100 MHz reference clock, all logic on posedge
// reset : synchronous active-high reset
// bus   : slave side of protocol_detect_if (raw pads in, registered detections out)
module protocol_detect
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int TBUF_CYCLES = TBUF_CYCLES_DEF
) (
    input logic              clk,
    input logic              reset,
    protocol_detect_if.slave bus
);

    // Pulses stay masked until the filter has flushed its reset preset.
    localparam int                    FILL_CYCLES = FILTER_LEN + 2;
    localparam int                    FILL_W      = $clog2(FILL_CYCLES + 1);
    localparam logic [FILL_W-1:0]     FILL_DONE   = FILL_W'(FILL_CYCLES);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST   = IDLE_CNT_W'(TBUF_CYCLES - 1);

    logic                  scl_f;
    logic                  sda_f;
    logic                  scl_q;
    logic                  sda_q;
    logic [FILL_W-1:0]     fill_cnt;
    logic                  ready;
    logic                  scl_high;
    logic                  start_cond;
    logic                  stop_cond;
    bus_state_t            state;
    logic [IDLE_CNT_W-1:0] idle_cnt;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (bus.scl_in),
        .filtered (scl_f)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
        .clk      (clk),
        .reset    (reset),
        .line_in  (bus.sda_in),
        .filtered (sda_f)
    );

    assign ready    = (fill_cnt == FILL_DONE);
    // SCL must be high on both sides of the SDA edge; a simultaneous SCL edge is not a condition.
    assign scl_high   = scl_f && scl_q;
    assign start_cond = ready && scl_high && sda_q && !sda_f;
    assign stop_cond  = ready && scl_high && !sda_q && sda_f;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_cnt       <= '0;
            scl_q          <= 1'b1;
            sda_q          <= 1'b1;
            bus.start_det  <= 1'b0;
            bus.rstart_det <= 1'b0;
            bus.stop_det   <= 1'b0;
            bus.scl_rise   <= 1'b0;
            bus.scl_fall   <= 1'b0;
        end else begin
            if (!ready) begin
                fill_cnt <= fill_cnt + FILL_W'(1);
            end
            scl_q          <= scl_f;
            sda_q          <= sda_f;
            bus.start_det  <= start_cond;
            bus.rstart_det <= start_cond && (state == BUSY);
            bus.stop_det   <= stop_cond;
            bus.scl_rise   <= ready && scl_f && !scl_q;
            bus.scl_fall   <= ready && !scl_f && scl_q;
        end
    end

    // Bus occupancy follows the registered condition pulses, one cycle behind them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= WAIT_FREE;
            idle_cnt     <= '0;
            bus.bus_busy <= 1'b0;
            bus.bus_free <= 1'b0;
        end else begin
            case (state)
                WAIT_FREE: begin
                    if (bus.start_det) begin
                        state        <= BUSY;
                        bus.bus_busy <= 1'b1;
                        idle_cnt     <= '0;
                    end else if (!(scl_f && sda_f)) begin
                        idle_cnt <= '0;
                    end else if (ready) begin
                        // Counter stops at IDLE_LAST; it is only cleared, never wrapped.
                        if (idle_cnt == IDLE_LAST) begin
                            state        <= FREE;
                            bus.bus_free <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
                        end
                    end
                end
                FREE: begin
                    // An SCL fall without START means another master is already talking.
                    if (bus.start_det || bus.scl_fall) begin
                        state        <= BUSY;
                        bus.bus_free <= 1'b0;
                        bus.bus_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (bus.stop_det) begin
                        state        <= WAIT_FREE;
                        bus.bus_busy <= 1'b0;
                        idle_cnt     <= '0;
                    end
                end
                default: begin
                    state        <= WAIT_FREE;
                    bus.bus_busy <= 1'b0;
                    bus.bus_free <= 1'b0;
                    idle_cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_protocol_detect.sv
// tb/tb_protocol_detect.sv - self-checking bench for protocol_detect against a behavioural model
module tb_protocol_detect;
    import i2c_pkg::*;

    localparam int FL   = FILTER_LEN_DEF;
    localparam int TB   = TBUF_CYCLES_DEF;
    localparam int FILL = FL + 2;
    localparam int LAT  = FL + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    protocol_detect_if bus_if ();

    protocol_detect #(.FILTER_LEN(FL), .TBUF_CYCLES(TB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raw sample history, filtered levels, reported events, bus occupancy.
    logic  hist_scl[$];
    logic  hist_sda[$];
    logic  m_scl, m_sda, m_scl_prev, m_sda_prev;
    logic  m_start, m_rstart, m_stop, m_rise, m_fall;
    int    m_age;
    int    m_idle;
    string m_bus;

    // A filtered line moves only when the delayed FL-sample window is unanimous.
    function automatic logic settle(input logic q[$], input logic cur);
        int ones = 0;
        for (int i = 3; i < 3 + FL; i++) begin
            if (q[i]) ones++;
        end
        if (ones == FL) return 1'b1;
        if (ones == 0)  return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        hist_scl = {};
        hist_sda = {};
        for (int i = 0; i < FL + 4; i++) begin
            hist_scl.push_front(1'b1);
            hist_sda.push_front(1'b1);
        end
        m_scl = 1'b1; m_sda = 1'b1; m_scl_prev = 1'b1; m_sda_prev = 1'b1;
        m_start = 1'b0; m_rstart = 1'b0; m_stop = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
        m_age = 0; m_idle = 0; m_bus = "wait";
    endtask

    task automatic model_edge();
        logic ready, n_start, n_stop, n_rise, n_fall;
        if (reset) begin
            model_reset();
            return;
        end
        ready   = (m_age >= FILL);
        n_start = ready && m_scl && m_scl_prev && m_sda_prev && !m_sda;
        n_stop  = ready && m_scl && m_scl_prev && !m_sda_prev && m_sda;
        n_rise  = ready && m_scl && !m_scl_prev;
        n_fall  = ready && !m_scl && m_scl_prev;
        m_rstart = n_start && (m_bus == "busy");
        if (m_bus == "busy") begin
            if (m_stop) begin m_bus = "wait"; m_idle = 0; end
        end else if (m_bus == "free") begin
            if (m_start || m_fall) m_bus = "busy";
        end else begin
            if (m_start) begin m_bus = "busy"; m_idle = 0; end
            else if (!(m_scl && m_sda)) m_idle = 0;
            else if (ready) begin
                if (m_idle == TB - 1) m_bus = "free";
                else m_idle++;
            end
        end
        m_start = n_start; m_stop = n_stop; m_rise = n_rise; m_fall = n_fall;
        hist_scl.push_front(bus_if.scl_in);
        hist_sda.push_front(bus_if.sda_in);
        void'(hist_scl.pop_back());
        void'(hist_sda.pop_back());
        m_scl_prev = m_scl;
        m_sda_prev = m_sda;
        m_scl = settle(hist_scl, m_scl);
        m_sda = settle(hist_sda, m_sda);
        m_age++;
    endtask

    // Observation bookkeeping for the directed timing checks.
    int   edge_n = 0;
    int   n_start_seen = 0, n_rstart_seen = 0, busy_cycles = 0;
    int   t_start = -1, t_rstart = -1, t_stop = -1, t_fall = -1;
    int   t_busy_up = -1, t_busy_dn = -1, t_free_up = -1;
    logic busy_d = 1'b0, free_d = 1'b0;

    task automatic step();
        @(posedge clk);
        if (reset) edge_n = 0; else edge_n++;
        model_edge();
        #1;
        check("start_det",  bus_if.start_det,  m_start);
        check("rstart_det", bus_if.rstart_det, m_rstart);
        check("stop_det",   bus_if.stop_det,   m_stop);
        check("scl_rise",   bus_if.scl_rise,   m_rise);
        check("scl_fall",   bus_if.scl_fall,   m_fall);
        check("bus_busy",   bus_if.bus_busy,   m_bus == "busy");
        check("bus_free",   bus_if.bus_free,   m_bus == "free");
        if (bus_if.start_det)  begin n_start_seen++;  t_start  = edge_n; end
        if (bus_if.rstart_det) begin n_rstart_seen++; t_rstart = edge_n; end
        if (bus_if.stop_det)   t_stop = edge_n;
        if (bus_if.scl_fall)   t_fall = edge_n;
        if (bus_if.bus_busy && !busy_d) t_busy_up = edge_n;
        if (!bus_if.bus_busy && busy_d) t_busy_dn = edge_n;
        if (bus_if.bus_free && !free_d) t_free_up = edge_n;
        if (bus_if.bus_busy) busy_cycles++;
        busy_d = bus_if.bus_busy;
        free_d = bus_if.bus_free;
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic set_lines(input logic scl, input logic sda);
        bus_if.scl_in = scl;
        bus_if.sda_in = sda;
    endtask

    initial begin
        int   t, n0, pulses;
        logic rs, rd;

        set_lines(1'b1, 1'b1);
        hold(3);
        check("reset_busy", bus_if.bus_busy, 1'b0);
        check("reset_free", bus_if.bus_free, 1'b0);
        reset = 1'b0;

        // Free-bus timer from reset.
        busy_cycles = 0;
        hold(600);
        check("tbuf_free_edge", t_free_up, FILL + TB);
        check("tbuf_no_busy", busy_cycles, 0);

        // START then STOP.
        n0 = n_start_seen;
        t  = edge_n + 1;
        set_lines(1'b1, 1'b0); hold(12);
        check("start_latency", t_start, t + LAT);
        check("start_busy_edge", t_busy_up, t + LAT + 1);
        check("start_once", n_start_seen - n0, 1);
        set_lines(1'b0, 1'b0); hold(10);
        set_lines(1'b1, 1'b0); hold(10);
        t = edge_n + 1;
        set_lines(1'b1, 1'b1); hold(12);
        check("stop_latency", t_stop, t + LAT);
        check("stop_idle_edge", t_busy_dn, t + LAT + 1);
        hold(TB + 10);
        check("stop_free_edge", t_free_up, t + LAT + 1 + TB);

        // Repeated START.
        set_lines(1'b1, 1'b0); hold(12);
        set_lines(1'b0, 1'b0); hold(10);
        set_lines(1'b0, 1'b1); hold(10);
        set_lines(1'b1, 1'b1); hold(10);
        n0 = n_rstart_seen;
        t  = edge_n + 1;
        set_lines(1'b1, 1'b0); hold(12);
        check("rstart_start", t_start, t + LAT);
        check("rstart_pulse", t_rstart, t + LAT);
        check("rstart_once", n_rstart_seen - n0, 1);
        check("rstart_busy", bus_if.bus_busy, 1'b1);

        // SCL and SDA falling together.
        set_lines(1'b0, 1'b0); hold(10);
        set_lines(1'b0, 1'b1); hold(10);
        set_lines(1'b1, 1'b1); hold(10);
        n0 = n_start_seen;
        t  = edge_n + 1;
        set_lines(1'b0, 1'b0); hold(12);
        check("simul_fall", t_fall, t + LAT);
        check("simul_no_start", n_start_seen - n0, 0);
        check("simul_busy", bus_if.bus_busy, 1'b1);

        // Glitch rejection, after a STOP.
        set_lines(1'b1, 1'b0); hold(10);
        set_lines(1'b1, 1'b1); hold(12);
        n0 = n_start_seen;
        set_lines(1'b1, 1'b0); hold(3);
        set_lines(1'b1, 1'b1); hold(15);
        check("glitch_rejected", n_start_seen - n0, 0);
        t = edge_n + 1;
        set_lines(1'b1, 1'b0); hold(8);
        set_lines(1'b1, 1'b1); hold(15);
        check("pulse_start", t_start, t + LAT);
        check("pulse_start_once", n_start_seen - n0, 1);

        // Randomized line activity including sub-filter glitches.
        repeat (250) begin
            rs = 1'($urandom_range(1, 0));
            rd = 1'($urandom_range(1, 0));
            set_lines(rs, rd);
            hold(int'($urandom_range(12, 1)));
        end

        // Reset in the middle of a transaction.
        set_lines(1'b1, 1'b1); hold(12);
        set_lines(1'b1, 1'b0); hold(12);
        set_lines(1'b0, 1'b0); hold(10);
        check("pre_reset_busy", bus_if.bus_busy, 1'b1);
        reset = 1'b1;
        hold(2);
        check("rst_mid_busy", bus_if.bus_busy, 1'b0);
        check("rst_mid_stop", bus_if.stop_det, 1'b0);
        reset = 1'b0;
        pulses = 0;
        repeat (FILL) begin
            step();
            if (bus_if.start_det || bus_if.rstart_det || bus_if.stop_det ||
                bus_if.scl_rise || bus_if.scl_fall) pulses++;
        end
        check("post_reset_quiet", pulses, 0);
        hold(20);
        check("post_reset_idle", bus_if.bus_busy, 1'b0);
        set_lines(1'b0, 1'b1); hold(10);
        set_lines(1'b1, 1'b1); hold(10);
        set_lines(1'b1, 1'b0); hold(12);
        check("new_start_busy", bus_if.bus_busy, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
